// File: rtl/pipearch_common_pkg.sv
// Shared pipearch definitions: arbiter tag constants plus the subset of the
// CCI-P c0 channel types used by the load-side blocks.
package pipearch_common;

   // Tag carried in the top bits of mdata, from bit 15 downward
   localparam int MAX_NUM_REQ = 8;
   localparam int ARB_TAG_MSB = 15;
   typedef logic [$clog2(MAX_NUM_REQ)-1:0] t_arb_tag;

   localparam int CCIP_CLADDR_W = 42;
   localparam int CCIP_CLDATA_W = 512;

   typedef enum logic [3:0] {
      eREQ_RDLINE_I = 4'h0,
      eREQ_RDLINE_S = 4'h1
   } t_ccip_c0_req;

   typedef enum logic [3:0] {
      eRSP_RDLINE = 4'h0,
      eRSP_UMSG   = 4'h4
   } t_ccip_c0_rsp;

   typedef struct packed {
      logic [1:0]               vc_sel;
      logic [1:0]               rsvd1;
      logic [1:0]               cl_len;
      t_ccip_c0_req             req_type;
      logic [5:0]               rsvd0;
      logic [CCIP_CLADDR_W-1:0] address;
      logic [15:0]              mdata;
   } t_cci_c0_ReqMemHdr;

   typedef struct packed {
      logic [1:0]   vc_used;
      logic         rsvd1;
      logic         hit_miss;
      logic [1:0]   rsvd0;
      logic [1:0]   cl_num;
      t_ccip_c0_rsp resp_type;
      logic [15:0]  mdata;
   } t_cci_c0_RspMemHdr;

   typedef struct packed {
      t_cci_c0_ReqMemHdr hdr;
      logic              valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_cci_c0_RspMemHdr        hdr;
      logic [CCIP_CLDATA_W-1:0] data;
      logic                     rspValid;
      logic                     mmioRdValid;
      logic                     mmioWrValid;
   } t_if_ccip_c0_Rx;

   function automatic logic cci_c0Rx_isReadRsp(input t_if_ccip_c0_Rx r);
      return r.rspValid && (r.hdr.resp_type == eRSP_RDLINE);
   endfunction

endpackage

// File: rtl/pipearch_rr_select.sv
// Round-robin one-hot picker: first eligible requester at or after rr_ptr,
// wrapping to the lowest eligible index. Purely combinational.
module pipearch_rr_select #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         eligible,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         grant
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] upper;
   logic               found;

   // Prefer eligible requesters at or above the pointer, else wrap around
   always_comb begin
      upper = '0;
      grant = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++)
         upper[j] = eligible[j] && (PTR_W'(j) >= rr_ptr);
      for (int j = 0; j < NUM_REQ; j++)
         if (!found && upper[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      for (int j = 0; j < NUM_REQ; j++)
         if (!found && eligible[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
   end

endmodule

// File: rtl/pipearch_c0_arbiter.sv
// CCI-P c0 read arbiter: round-robin shares the c0 request channel among
// NUM_REQ load requesters, tags mdata with the requester index and routes
// read responses back by tag. Per-requester in-flight caps bound traffic.
// Optional: PIPEARCH_C0ARB_STATS_EN adds per-requester grant counters.
module pipearch_c0_arbiter
   import pipearch_common::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 64
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic              [NUM_REQ-1:0]     req_valid,
   input  t_cci_c0_ReqMemHdr [NUM_REQ-1:0]     req_hdr,
   output logic              [NUM_REQ-1:0]     req_grant,
   input  logic                                c0TxAlmFull,
   output t_if_ccip_c0_Tx                      af2cp_sTx_c0,
   input  t_if_ccip_c0_Rx                      cp2af_sRx_c0,
   output logic              [NUM_REQ-1:0]     rsp_valid,
   output logic              [CCIP_CLDATA_W-1:0] rsp_data,
   output logic                                busy
`ifdef PIPEARCH_C0ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][31:0]            stat_grants
`endif
);
   localparam int ID_BITS = $clog2(NUM_REQ);
   localparam int CNT_W   = 10;

   logic [ID_BITS-1:0]              rr_ptr;
   logic [ID_BITS-1:0]              gnt_idx;
   logic [NUM_REQ-1:0]              eligible;
   logic [NUM_REQ-1:0][CNT_W-1:0]   outstanding;
   logic [NUM_REQ-1:0][CNT_W-1:0]   outstanding_d;
   t_cci_c0_ReqMemHdr               fwd_hdr;
   logic [ID_BITS-1:0]              rsp_idx;
   t_arb_tag                        rsp_tag;
   logic                            rsp_hit;
   logic [NUM_REQ-1:0]              rsp_onehot;
   logic                            unused_rx;

   // A requester may win only with a pending header, room under its cap
   // and a channel that is not back-pressured
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_valid[i] && !c0TxAlmFull &&
                       (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
   end

   pipearch_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .grant    (req_grant)
   );

   // Mux the winning header and stamp its index into the mdata tag field
   always_comb begin
      gnt_idx = '0;
      fwd_hdr = '0;
      for (int j = 0; j < NUM_REQ; j++)
         if (req_grant[j]) begin
            gnt_idx = ID_BITS'(j);
            fwd_hdr = req_hdr[j];
         end
      fwd_hdr.mdata[ARB_TAG_MSB -: ID_BITS] = gnt_idx;
   end

   // Pointer moves just past the last winner; holds when nobody wins
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         rr_ptr <= '0;
      else if (|req_grant)
         rr_ptr <= (gnt_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   // Registered request channel, one cycle behind the grant
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         af2cp_sTx_c0 <= '0;
      else begin
         af2cp_sTx_c0.valid <= |req_grant;
         if (|req_grant)
            af2cp_sTx_c0.hdr <= fwd_hdr;
      end

   // Response routing: tags beyond the requester range are dropped
   assign rsp_idx = cp2af_sRx_c0.hdr.mdata[ARB_TAG_MSB -: ID_BITS];
   assign rsp_tag = t_arb_tag'(rsp_idx);
   assign rsp_hit = cci_c0Rx_isReadRsp(cp2af_sRx_c0) &&
                    ({1'b0, rsp_tag} < 4'(NUM_REQ));

   // Decode the response tag into a per-requester strobe
   always_comb begin
      rsp_onehot = '0;
      for (int j = 0; j < NUM_REQ; j++)
         rsp_onehot[j] = rsp_hit && (rsp_idx == ID_BITS'(j));
   end

   // Registered response strobe and line
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rsp_onehot;
         if (rsp_hit)
            rsp_data <= cp2af_sRx_c0.data;
      end

   // In-flight counters: grant and response in one cycle cancel, and a
   // stray response at zero leaves the counter at zero
   always_comb begin
      outstanding_d = outstanding;
      for (int i = 0; i < NUM_REQ; i++)
         if (req_grant[i] && !rsp_onehot[i])
            outstanding_d[i] = outstanding[i] + 1'b1;
         else if (rsp_onehot[i] && !req_grant[i] && (outstanding[i] != '0))
            outstanding_d[i] = outstanding[i] - 1'b1;
   end

   // busy follows the counter state that is being registered
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         outstanding <= '0;
         busy        <= 1'b0;
      end else begin
         outstanding <= outstanding_d;
         busy        <= |outstanding_d;
      end

`ifdef PIPEARCH_C0ARB_STATS_EN
   // Per-requester grant counters, wrapping modulo 2^32
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         stat_grants <= '0;
      else
         for (int i = 0; i < NUM_REQ; i++)
            if (req_grant[i])
               stat_grants[i] <= stat_grants[i] + 32'd1;
`else
   // Statistics disabled: no grant counters are built
`endif

   // MMIO strobes and most response header fields are not needed here
   assign unused_rx = ^{cp2af_sRx_c0.mmioRdValid, cp2af_sRx_c0.mmioWrValid,
                        cp2af_sRx_c0.hdr};

endmodule

// File: tb/tb_pipearch_c0_arbiter.sv
// Directed bench for pipearch_c0_arbiter: a table of per-cycle vectors on a
// 4-requester instance with a cap of 2, plus hand sequences on a
// 3-requester instance for out-of-range tags and mid-traffic reset.
module tb_pipearch_c0_arbiter;
   import pipearch_common::*;

   localparam int N  = 4;
   localparam int N3 = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]              req_valid, req_grant, rsp_valid;
   t_cci_c0_ReqMemHdr [N-1:0] req_hdr;
   logic                      c0TxAlmFull;
   t_if_ccip_c0_Tx            tx;
   t_if_ccip_c0_Rx            rx;
   logic [511:0]              rsp_data;
   logic                      busy;

   logic [N3-1:0]              req_valid3, req_grant3, rsp_valid3;
   t_cci_c0_ReqMemHdr [N3-1:0] req_hdr3;
   t_if_ccip_c0_Tx             tx3;
   logic [511:0]               rsp_data3;
   logic                       busy3;
`ifdef PIPEARCH_C0ARB_STATS_EN
   logic [N-1:0][31:0]  stat_grants;
   logic [N3-1:0][31:0] stat_grants3;
`endif

   pipearch_c0_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_hdr(req_hdr),
      .req_grant(req_grant), .c0TxAlmFull(c0TxAlmFull), .af2cp_sTx_c0(tx),
      .cp2af_sRx_c0(rx), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
`ifdef PIPEARCH_C0ARB_STATS_EN
      , .stat_grants(stat_grants)
`endif
   );

   pipearch_c0_arbiter #(.NUM_REQ(N3), .MAX_OUTSTANDING(64)) dut3 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_hdr(req_hdr3),
      .req_grant(req_grant3), .c0TxAlmFull(c0TxAlmFull), .af2cp_sTx_c0(tx3),
      .cp2af_sRx_c0(rx), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3)
`ifdef PIPEARCH_C0ARB_STATS_EN
      , .stat_grants(stat_grants3)
`endif
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic t_cci_c0_ReqMemHdr exp_hdr(input t_cci_c0_ReqMemHdr h, input logic [1:0] tag);
      exp_hdr = h;
      exp_hdr.mdata[15:14] = tag;
   endfunction

   typedef struct {
      logic [3:0] rv;     // req_valid
      logic       af;     // c0TxAlmFull
      logic       rr;     // response present
      logic       rd;     // response is a read
      logic [1:0] tag;    // response tag
      logic [3:0] g;      // expected grant this cycle
      logic       txv;    // expected Tx valid after the edge
      logic [1:0] txtag;  // expected forwarded requester
      logic [3:0] rspv;   // expected rsp_valid after the edge
      logic       bsy;    // expected busy after the edge
   } vec_t;

   function automatic vec_t mk(input int rv, af, rr, rd, tag, g, txv, txtag, rspv, bsy);
      vec_t m;
      m.rv = 4'(rv);  m.af = 1'(af);   m.rr = 1'(rr);     m.rd = 1'(rd);
      m.tag = 2'(tag); m.g = 4'(g);    m.txv = 1'(txv);   m.txtag = 2'(txtag);
      m.rspv = 4'(rspv); m.bsy = 1'(bsy);
      return m;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [511:0] dat;
      req_valid = '0; req_valid3 = '0; c0TxAlmFull = 1'b0; rx = '0;
      for (int i = 0; i < N; i++) begin
         req_hdr[i] = '0;
         req_hdr[i].vc_sel   = 2'h1;
         req_hdr[i].cl_len   = 2'h0;
         req_hdr[i].req_type = eREQ_RDLINE_S;
         req_hdr[i].address  = 42'h100 + 42'(i * 3);
         req_hdr[i].mdata    = 16'hCAB0 + 16'(i);
      end
      for (int i = 0; i < N3; i++) begin
         req_hdr3[i] = req_hdr[i];
         req_hdr3[i].address = 42'h900 + 42'(i);
      end

      //          rv  af rr rd tag  g  txv tt rspv bsy
      // four requesters back to back: 0,1,2,3,0
      vecs.push_back(mk(15, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk(15, 0, 0, 0, 0, 2, 1, 1, 0, 1));
      vecs.push_back(mk(15, 0, 0, 0, 0, 4, 1, 2, 0, 1));
      vecs.push_back(mk(15, 0, 0, 0, 0, 8, 1, 3, 0, 1));
      vecs.push_back(mk(15, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // back-pressure holds requester 2 off for three cycles
      vecs.push_back(mk( 4, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk( 4, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk( 4, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk( 4, 0, 0, 0, 0, 4, 1, 2, 0, 1));
      vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // drain counters 2,1,2,1; a non-read is ignored; a stray at zero saturates
      vecs.push_back(mk( 0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk( 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 1, 0, 0, 0, 2, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 2, 0, 0, 0, 4, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 2, 0, 0, 0, 4, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 3, 0, 0, 0, 8, 0));
      vecs.push_back(mk( 0, 0, 1, 1, 1, 0, 0, 0, 2, 0));
      // cap of 2 on requester 1: two grants, stall, response frees one slot
      vecs.push_back(mk( 2, 0, 0, 0, 0, 2, 1, 1, 0, 1));
      vecs.push_back(mk( 2, 0, 0, 0, 0, 2, 1, 1, 0, 1));
      vecs.push_back(mk( 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk( 2, 0, 1, 1, 1, 0, 0, 0, 2, 1));
      vecs.push_back(mk( 2, 0, 0, 0, 0, 2, 1, 1, 0, 1));
      // grant and response in one cycle leave the counter at 1
      vecs.push_back(mk( 0, 0, 1, 1, 1, 0, 0, 0, 2, 1));
      vecs.push_back(mk( 2, 0, 1, 1, 1, 2, 1, 1, 2, 1));
      vecs.push_back(mk( 2, 0, 0, 0, 0, 2, 1, 1, 0, 1));
      vecs.push_back(mk( 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // sparse mask with pointer at 2, then wrap search from 1
      vecs.push_back(mk( 9, 0, 0, 0, 0, 8, 1, 3, 0, 1));
      vecs.push_back(mk( 9, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      vecs.push_back(mk( 9, 0, 0, 0, 0, 8, 1, 3, 0, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 3, 0, 0, 0, 8, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 3, 0, 0, 0, 8, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 1, 0, 0, 0, 2, 1));
      vecs.push_back(mk( 0, 0, 1, 1, 1, 0, 0, 0, 2, 0));

      // reset state
      #2;
      chk("rst_txv",   512'(tx.valid), 512'(0));
      chk("rst_rspv",  512'(rsp_valid), 512'(0));
      chk("rst_data",  rsp_data, 512'(0));
      chk("rst_busy",  512'(busy), 512'(0));
      chk("rst_busy3", 512'(busy3), 512'(0));
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[k]) begin
         vec_t v;
         v = vecs[k];
         @(negedge clk);
         req_valid   = v.rv;
         c0TxAlmFull = v.af;
         dat = {16{32'hD0000000 | 32'(k)}};
         rx = '0;
         rx.rspValid      = v.rr;
         rx.hdr.resp_type = v.rd ? eRSP_RDLINE : eRSP_UMSG;
         rx.hdr.mdata     = {v.tag, 14'h2A5A};
         rx.data          = dat;
         #1;
         chk($sformatf("grant[%0d]", k), 512'(req_grant), 512'(v.g));
         @(posedge clk);
         #1;
         chk($sformatf("txv[%0d]", k), 512'(tx.valid), 512'(v.txv));
         if (v.txv)
            chk($sformatf("txhdr[%0d]", k), 512'(tx.hdr),
                512'(exp_hdr(req_hdr[v.txtag], v.txtag)));
         chk($sformatf("rspv[%0d]", k), 512'(rsp_valid), 512'(v.rspv));
         if (v.rspv != 4'h0)
            chk($sformatf("rspdata[%0d]", k), rsp_data, dat);
         chk($sformatf("busy[%0d]", k), 512'(busy), 512'(v.bsy));
      end

      // three requesters: tag 3 is out of range and is dropped
      @(negedge clk);
      req_valid = '0; c0TxAlmFull = 1'b0; rx = '0; req_valid3 = 3'b001;
      #1 chk("n3_grant0", 512'(req_grant3), 512'(3'b001));
      @(posedge clk); #1;
      chk("n3_txv", 512'(tx3.valid), 512'(1));
      chk("n3_txhdr", 512'(tx3.hdr), 512'(exp_hdr(req_hdr3[0], 2'd0)));
      chk("n3_busy_a", 512'(busy3), 512'(1));
      @(negedge clk);
      req_valid3 = '0;
      rx.rspValid = 1'b1; rx.hdr.resp_type = eRSP_RDLINE;
      rx.hdr.mdata = 16'hC123; rx.data = {16{32'hBADBAD00}};
      @(posedge clk); #1;
      chk("n3_drop_rspv", 512'(rsp_valid3), 512'(0));
      chk("n3_drop_busy", 512'(busy3), 512'(1));
      @(negedge clk);
      rx.hdr.mdata = 16'h0123; rx.data = {16{32'h600D600D}};
      @(posedge clk); #1;
      chk("n3_rspv", 512'(rsp_valid3), 512'(3'b001));
      chk("n3_rspdata", rsp_data3, {16{32'h600D600D}});
      chk("n3_busy_b", 512'(busy3), 512'(0));

      // asynchronous reset in the middle of traffic
      @(negedge clk);
      rx = '0; req_valid3 = 3'b111; req_valid = 4'hF;
      #1 chk("n3_grant1", 512'(req_grant3), 512'(3'b010));
      @(posedge clk); #1;
      chk("pre_rst_txv3", 512'(tx3.valid), 512'(1));
      chk("pre_rst_busy3", 512'(busy3), 512'(1));
      #2 reset_n = 1'b0;
      #1;
      chk("arst_txv3",  512'(tx3.valid), 512'(0));
      chk("arst_busy3", 512'(busy3), 512'(0));
      chk("arst_data3", rsp_data3, 512'(0));
      chk("arst_txv",   512'(tx.valid), 512'(0));
      chk("arst_busy",  512'(busy), 512'(0));
      @(negedge clk);
      reset_n = 1'b1; req_valid = '0; req_valid3 = 3'b110;
      #1 chk("post_rst_grant3", 512'(req_grant3), 512'(3'b010));
      @(posedge clk); #1;
      chk("post_rst_txhdr3", 512'(tx3.hdr), 512'(exp_hdr(req_hdr3[1], 2'd1)));
      @(negedge clk);
      req_valid3 = '0;

`ifdef PIPEARCH_C0ARB_STATS_EN
      // ten grants to requester 0, each cancelled by a same-cycle response
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = 4'b0001;
         rx = '0; rx.rspValid = 1'b1; rx.hdr.resp_type = eRSP_RDLINE;
         rx.hdr.mdata = 16'h0000;
      end
      @(negedge clk);
      req_valid = '0; rx = '0;
      #1;
      chk("stat0", 512'(stat_grants[0]), 512'(10));
      for (int i = 1; i < N; i++)
         chk($sformatf("stat%0d", i), 512'(stat_grants[i]), 512'(0));
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/pipearch_c0_arbiter.md
PIPEARCH_C0_ARBITER -- requirements
Module: pipearch_c0_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of load requesters sharing CCI-P c0; legal values 2..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 64: per-requester cap on lines in flight; legal values 1..511.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is in this domain.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: bit i means requester i presents a read header.
REQ-006 SHALL have port req_hdr, input, NUM_REQ x t_cci_c0_ReqMemHdr: read headers, one per requester.
REQ-007 SHALL have port req_grant, output, NUM_REQ bits: one-hot, combinational, asserted in the cycle the header is accepted.
REQ-008 SHALL have port c0TxAlmFull, input, 1 bit: CCI-P c0 back-pressure.
REQ-009 SHALL have port af2cp_sTx_c0, output, t_if_ccip_c0_Tx: registered shared request channel.
REQ-010 SHALL have port cp2af_sRx_c0, input, t_if_ccip_c0_Rx: shared response channel.
REQ-011 SHALL have port rsp_valid, output, NUM_REQ bits: one-hot, registered read-response strobe per requester.
REQ-012 SHALL have port rsp_data, output, 512 bits: registered response line, common to all requesters.
REQ-013 SHALL have port busy, output, 1 bit: registered; high while any outstanding counter is nonzero.

Function
REQ-014 SHALL grant at most one requester per cycle, and only when c0TxAlmFull=0.
REQ-015 A requester SHALL be eligible only if req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-016 Grants SHALL be round-robin: search starts at rr_ptr; on a grant to i, rr_ptr becomes (i+1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-017 af2cp_sTx_c0 SHALL be registered, 1-cycle latency: valid=1 in the cycle after a grant, carrying the granted header.
REQ-018 In the forwarded header, mdata[15:16-ID_BITS] SHALL be overwritten with the requester index; the remaining mdata bits, address, req_type, vc_sel and cl_len SHALL pass unchanged.
REQ-019 ID_BITS SHALL be $clog2(NUM_REQ).
REQ-020 af2cp_sTx_c0.valid SHALL be 0 in every cycle not immediately following a grant.
REQ-021 On a read response (cci_c0Rx_isReadRsp), the block SHALL, one cycle later, assert rsp_valid[tag] with rsp_data = response data; tag = mdata[15:16-ID_BITS].
REQ-022 Non-read responses SHALL be ignored.
REQ-023 A response with tag >= NUM_REQ SHALL be dropped, and no counter SHALL change.
REQ-024 outstanding[i] SHALL be 10 bits; +1 on a grant to i; -1 on a response to i; unchanged when both happen in the same cycle.
REQ-025 A response arriving at outstanding[i]=0 SHALL not wrap; the counter saturates at 0.
REQ-026 The block SHALL be stateless across requests apart from rr_ptr and the counters; it has no FIFO.
REQ-027 Requesters SHALL hold req_valid/req_hdr until granted; the block does not latch un-granted headers.

Reset
REQ-028 Reset assertion SHALL asynchronously clear all registered outputs (valid bits 0, rsp_data 0, busy 0), rr_ptr to 0, and all counters.
REQ-029 Responses to requests in flight when reset is asserted SHALL be discarded; reset mid-operation requires the system to quiesce CCI-P first.

Configuration
REQ-030 With PIPEARCH_C0ARB_STATS_EN defined, the block SHALL add output stat_grants, NUM_REQ x 32 bits: per-requester grant counters that wrap modulo 2^32 and clear on reset.
REQ-031 Without PIPEARCH_C0ARB_STATS_EN, stat_grants SHALL be absent and its logic SHALL not be synthesized.

Structure
REQ-032 MAX_NUM_REQ=8, the tag-position constant (mdata bit 15 downward) and the t_arb_tag typedef SHALL reside in the shared pipearch_common package.
REQ-033 Round-robin selection SHALL be a sub-module, pipearch_rr_select: inputs eligible mask and rr_ptr; output one-hot grant; purely combinational.

Verification
REQ-034 Reset, NUM_REQ=4, req_valid=4'b1111 held, AlmFull=0 -> grants 0,1,2,3,0 on consecutive cycles; Tx valid each following cycle with mdata[15:14]=00,01,10,11,00.
REQ-035 req_valid=4'b0100, AlmFull=1 for 3 cycles then 0 -> no grant during the 3 cycles; grant=4'b0100 on the 4th cycle; Tx valid on the 5th with the header otherwise unchanged.
REQ-036 MAX_OUTSTANDING=2, requester 1 only, no responses -> exactly 2 grants, then stall; one response with tag 01 -> rsp_valid=4'b0010 one cycle later, then a third grant follows.
REQ-037 Grant to 2 and response tagged 10 in the same cycle with outstanding[2]=5 -> outstanding[2] stays 5.
REQ-038 NUM_REQ=3, response tag 11 -> no rsp_valid, counters unchanged; reset_n pulsed low mid-traffic -> outputs 0 immediately, busy=0.
REQ-039 STATS_EN build with 10 grants to requester 0 -> stat_grants[0]=10, others 0.
